// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - control/PC bundle between the EX-stage decoder and fetch_sequencer
interface fetch_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             stall_in;
  logic             halt_req;
  logic [2:0]       inst_type_EX;
  logic             branch_taken;
  logic [11:0]      branch_addr;
  logic [11:0]      jal_addr;
  logic [11:0]      jalr_addr;
  logic [11:0]      prog_counter_F;
  logic [11:0]      prog_counter_EX;
  logic             valid_EX;
  logic             redirect;
  logic             halted;
  logic [CNT_W-1:0] taken_cnt;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output stall_in, halt_req, inst_type_EX, branch_taken,
    output branch_addr, jal_addr, jalr_addr,
    input  prog_counter_F, prog_counter_EX, valid_EX, redirect, halted,
    input  taken_cnt, bubble_cnt
  );

  modport slave (
    input  stall_in, halt_req, inst_type_EX, branch_taken,
    input  branch_addr, jal_addr, jalr_addr,
    output prog_counter_F, prog_counter_EX, valid_EX, redirect, halted,
    output taken_cnt, bubble_cnt
  );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC sequencer for the 2-stage Fetch/EX pipeline
// Optional statistics counters are built only when FETCH_STATS_EN is defined.
module fetch_sequencer #(
  parameter logic [11:0] RESET_PC = 12'h000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  fetch_sequencer_if.slave bus
);

  localparam logic [2:0] TYPE_B    = 3'b100;
  localparam logic [2:0] TYPE_JAL  = 3'b101;
  localparam logic [2:0] TYPE_JALR = 3'b110;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      r_state;
  logic [11:0] r_pc_f;
  logic [11:0] r_pc_ex;
  logic        r_valid_ex;
  logic        r_halted;

  logic        w_ctrl_taken;
  logic        w_redirect;
  logic [11:0] w_target;
  logic [11:0] w_pc_seq;

  always_comb begin
    w_ctrl_taken = 1'b0;
    w_target     = bus.branch_addr;
    case (bus.inst_type_EX)
      TYPE_B: begin
        w_ctrl_taken = bus.branch_taken;
        w_target     = bus.branch_addr;
      end
      TYPE_JAL: begin
        w_ctrl_taken = 1'b1;
        w_target     = bus.jal_addr;
      end
      TYPE_JALR: begin
        w_ctrl_taken = 1'b1;
        w_target     = bus.jalr_addr;
      end
      default: begin
        w_ctrl_taken = 1'b0;
        w_target     = bus.branch_addr;
      end
    endcase
  end

  // A bubble in EX (valid_EX=0) can never redirect, which also masks BOOT and FLUSH.
  assign w_redirect = r_valid_ex & (r_state != S_HALT) & w_ctrl_taken;
  assign w_pc_seq   = r_pc_f + 12'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_BOOT;
      r_pc_f     <= RESET_PC;
      r_pc_ex    <= RESET_PC;
      r_valid_ex <= 1'b0;
      r_halted   <= 1'b0;
    end else if (bus.halt_req || r_state == S_HALT) begin
      r_state    <= S_HALT;
      r_valid_ex <= 1'b0;
      r_halted   <= 1'b1;
    end else if (w_redirect) begin
      // Redirect beats stall; only the EX PC honours the stall.
      r_state    <= S_FLUSH;
      r_pc_f     <= w_target;
      r_valid_ex <= 1'b0;
      if (!bus.stall_in) begin
        r_pc_ex <= r_pc_f;
      end
    end else if (!bus.stall_in) begin
      r_state    <= S_RUN;
      r_pc_ex    <= r_pc_f;
      r_pc_f     <= w_pc_seq;
      r_valid_ex <= (r_state != S_BOOT);
    end
  end

  assign bus.prog_counter_F  = r_pc_f;
  assign bus.prog_counter_EX = r_pc_ex;
  assign bus.valid_EX        = r_valid_ex;
  assign bus.redirect        = w_redirect;
  assign bus.halted          = r_halted;

`ifdef FETCH_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_taken_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_taken_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_redirect && (r_taken_cnt != '1)) begin
        r_taken_cnt <= r_taken_cnt + CNT_ONE;
      end
      if (!r_valid_ex && (r_state != S_HALT) && (r_bubble_cnt != '1)) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
      end
    end
  end

  assign bus.taken_cnt  = r_taken_cnt;
  assign bus.bubble_cnt = r_bubble_cnt;
`else
  assign bus.taken_cnt  = {CNT_W{1'b0}};
  assign bus.bubble_cnt = {CNT_W{1'b0}};
`endif

endmodule
